// File: rtl/ctrl_pipe_if.sv
// Control-word bundle between the hazard/control logic and the pipe registers.
// master drives D-stage control, stall/flush/zero; slave returns E/M/W copies.
interface ctrl_pipe_if #(
    parameter int RD_W   = 5,
    parameter int ALUC_W = 3,
    parameter int CNT_W  = 32
);
    logic              valid_d;
    logic              reg_write_d;
    logic              alu_src_d;
    logic              mem_write_d;
    logic              result_src_d;
    logic              branch_d;
    logic [ALUC_W-1:0] alu_control_d;
    logic [RD_W-1:0]   rd_d;
    logic              stall_e;
    logic              flush_e;
    logic              zero_e;

    logic              alu_src_e;
    logic [ALUC_W-1:0] alu_control_e;
    logic              branch_e;
    logic [RD_W-1:0]   rd_e;
    logic              valid_e;
    logic              pc_src_e;
    logic              reg_write_m;
    logic              mem_write_m;
    logic              result_src_m;
    logic [RD_W-1:0]   rd_m;
    logic              valid_m;
    logic              reg_write_w;
    logic              result_src_w;
    logic [RD_W-1:0]   rd_w;
    logic              valid_w;
    logic [CNT_W-1:0]  retired_count;

    modport master (
        output valid_d, reg_write_d, alu_src_d, mem_write_d, result_src_d,
        output branch_d, alu_control_d, rd_d, stall_e, flush_e, zero_e,
        input  alu_src_e, alu_control_e, branch_e, rd_e, valid_e, pc_src_e,
        input  reg_write_m, mem_write_m, result_src_m, rd_m, valid_m,
        input  reg_write_w, result_src_w, rd_w, valid_w, retired_count
    );

    modport slave (
        input  valid_d, reg_write_d, alu_src_d, mem_write_d, result_src_d,
        input  branch_d, alu_control_d, rd_d, stall_e, flush_e, zero_e,
        output alu_src_e, alu_control_e, branch_e, rd_e, valid_e, pc_src_e,
        output reg_write_m, mem_write_m, result_src_m, rd_m, valid_m,
        output reg_write_w, result_src_w, rd_w, valid_w, retired_count
    );
endinterface

// File: rtl/ctrl_pipe_regs.sv
// D->E->M->W control pipeline registers with stall/flush, branch select
// and retired-instruction counter.
// Ports: clk, rst (sync, active-high), bus (ctrl_pipe_if.slave):
//   in : *_d control word, stall_e, flush_e, zero_e
//   out: E/M/W registered copies, pc_src_e, retired_count
module ctrl_pipe_regs #(
    parameter int RD_W   = 5,
    parameter int ALUC_W = 3,
    parameter int CNT_W  = 32
) (
    input  logic         clk,
    input  logic         rst,
    ctrl_pipe_if.slave   bus
);
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              alu_src;
        logic              mem_write;
        logic              result_src;
        logic              branch;
        logic [ALUC_W-1:0] alu_control;
        logic [RD_W-1:0]   rd;
    } e_word_t;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_write;
        logic            result_src;
        logic [RD_W-1:0] rd;
    } m_word_t;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            result_src;
        logic [RD_W-1:0] rd;
    } w_word_t;

    e_word_t          d_word;
    e_word_t          e_q, e_next;
    m_word_t          m_q, m_next;
    w_word_t          w_q, w_next;
    logic [CNT_W-1:0] cnt_q;

    // An invalid D slot is squashed to an all-zero bubble on capture.
    always_comb begin
        d_word = '0;
        if (bus.valid_d) begin
            d_word.valid       = 1'b1;
            d_word.reg_write   = bus.reg_write_d;
            d_word.alu_src     = bus.alu_src_d;
            d_word.mem_write   = bus.mem_write_d;
            d_word.result_src  = bus.result_src_d;
            d_word.branch      = bus.branch_d;
            d_word.alu_control = bus.alu_control_d;
            d_word.rd          = bus.rd_d;
        end
    end

    // Flush beats stall in E; a stalled E sends a bubble into M.
    always_comb begin
        e_next = d_word;
        if (bus.flush_e) begin
            e_next = '0;
        end else if (bus.stall_e) begin
            e_next = e_q;
        end

        m_next = '0;
        if (!bus.stall_e) begin
            m_next.valid      = e_q.valid;
            m_next.reg_write  = e_q.reg_write;
            m_next.mem_write  = e_q.mem_write;
            m_next.result_src = e_q.result_src;
            m_next.rd         = e_q.rd;
        end

        w_next            = '0;
        w_next.valid      = m_q.valid;
        w_next.reg_write  = m_q.reg_write;
        w_next.result_src = m_q.result_src;
        w_next.rd         = m_q.rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q <= e_next;
            m_q <= m_next;
            w_q <= w_next;
            if (w_q.valid) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.valid_e       = e_q.valid;
    assign bus.alu_src_e     = e_q.alu_src;
    assign bus.alu_control_e = e_q.alu_control;
    assign bus.branch_e      = e_q.branch;
    assign bus.rd_e          = e_q.rd;
    assign bus.pc_src_e      = e_q.valid & e_q.branch & bus.zero_e;

    assign bus.valid_m       = m_q.valid;
    assign bus.reg_write_m   = m_q.reg_write;
    assign bus.mem_write_m   = m_q.mem_write;
    assign bus.result_src_m  = m_q.result_src;
    assign bus.rd_m          = m_q.rd;

    assign bus.valid_w       = w_q.valid;
    assign bus.reg_write_w   = w_q.reg_write;
    assign bus.result_src_w  = w_q.result_src;
    assign bus.rd_w          = w_q.rd;

    assign bus.retired_count = cnt_q;
endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Self-checking bench for ctrl_pipe_regs: directed vector table, counter
// wrap on a 4-bit-counter instance, and randomized run against a model.
module tb_ctrl_pipe_regs;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_pipe_if #(.RD_W(5), .ALUC_W(3), .CNT_W(32)) b ();
    ctrl_pipe_if #(.RD_W(5), .ALUC_W(3), .CNT_W(4))  b4 ();

    ctrl_pipe_regs #(.RD_W(5), .ALUC_W(3), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(b.slave)
    );
    ctrl_pipe_regs #(.RD_W(5), .ALUC_W(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(b4.slave)
    );

    assign b4.valid_d       = b.valid_d;
    assign b4.reg_write_d   = b.reg_write_d;
    assign b4.alu_src_d     = b.alu_src_d;
    assign b4.mem_write_d   = b.mem_write_d;
    assign b4.result_src_d  = b.result_src_d;
    assign b4.branch_d      = b.branch_d;
    assign b4.alu_control_d = b.alu_control_d;
    assign b4.rd_d          = b.rd_d;
    assign b4.stall_e       = b.stall_e;
    assign b4.flush_e       = b.flush_e;
    assign b4.zero_e        = b.zero_e;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, vd, rw, asrc, mw, rs, br,
                         input logic [2:0] alu, input logic [4:0] rd,
                         input logic st, fl, z);
        rst               = r;
        b.valid_d         = vd;
        b.reg_write_d     = rw;
        b.alu_src_d       = asrc;
        b.mem_write_d     = mw;
        b.result_src_d    = rs;
        b.branch_d        = br;
        b.alu_control_d   = alu;
        b.rd_d            = rd;
        b.stall_e         = st;
        b.flush_e         = fl;
        b.zero_e          = z;
    endtask

    typedef struct {
        logic        r, vd, rw, asrc, mw, rs, br;
        logic [2:0]  alu;
        logic [4:0]  rd;
        logic        st, fl, z;
        logic        ve;
        logic [4:0]  rde;
        logic        vm, rwm, vw, rww;
        logic [4:0]  rdw;
        logic [31:0] cnt;
        logic        pcs;
    } vec_t;

    function automatic vec_t mk(input int r, vd, rw, asrc, mw, rs, br, alu,
                                rd, st, fl, z, ve, rde, vm, rwm, vw, rww,
                                rdw, cnt, pcs);
        vec_t v;
        v.r = r[0]; v.vd = vd[0]; v.rw = rw[0]; v.asrc = asrc[0];
        v.mw = mw[0]; v.rs = rs[0]; v.br = br[0]; v.alu = alu[2:0];
        v.rd = rd[4:0]; v.st = st[0]; v.fl = fl[0]; v.z = z[0];
        v.ve = ve[0]; v.rde = rde[4:0]; v.vm = vm[0]; v.rwm = rwm[0];
        v.vw = vw[0]; v.rww = rww[0]; v.rdw = rdw[4:0]; v.cnt = cnt;
        v.pcs = pcs[0];
        return v;
    endfunction

    // Reference model: one record per stage holding the whole instruction.
    typedef struct {
        logic       valid, rw, asrc, mw, rs, br;
        logic [2:0] alu;
        logic [4:0] rd;
    } ins_t;

    ins_t        stg_e, stg_m, stg_w;
    logic [31:0] mcnt;

    task automatic cmp_model(input string tag);
        chk({tag, " valid_e"}, 32'(b.valid_e), 32'(stg_e.valid));
        chk({tag, " alu_src_e"}, 32'(b.alu_src_e), 32'(stg_e.asrc));
        chk({tag, " alu_control_e"}, 32'(b.alu_control_e), 32'(stg_e.alu));
        chk({tag, " branch_e"}, 32'(b.branch_e), 32'(stg_e.br));
        chk({tag, " rd_e"}, 32'(b.rd_e), 32'(stg_e.rd));
        chk({tag, " pc_src_e"}, 32'(b.pc_src_e),
            32'(stg_e.valid && stg_e.br && b.zero_e));
        chk({tag, " valid_m"}, 32'(b.valid_m), 32'(stg_m.valid));
        chk({tag, " reg_write_m"}, 32'(b.reg_write_m), 32'(stg_m.rw));
        chk({tag, " mem_write_m"}, 32'(b.mem_write_m), 32'(stg_m.mw));
        chk({tag, " result_src_m"}, 32'(b.result_src_m), 32'(stg_m.rs));
        chk({tag, " rd_m"}, 32'(b.rd_m), 32'(stg_m.rd));
        chk({tag, " valid_w"}, 32'(b.valid_w), 32'(stg_w.valid));
        chk({tag, " reg_write_w"}, 32'(b.reg_write_w), 32'(stg_w.rw));
        chk({tag, " result_src_w"}, 32'(b.result_src_w), 32'(stg_w.rs));
        chk({tag, " rd_w"}, 32'(b.rd_w), 32'(stg_w.rd));
        chk({tag, " retired_count"}, b.retired_count, mcnt);
        chk({tag, " retired_count4"}, 32'(b4.retired_count), mcnt & 32'hf);
    endtask

    vec_t tbl[19];

    initial begin
        tbl[0]  = mk(1,1,1,1,1,1,1,7,31,1,1,1, 0,0,0,0,0,0,0,0,0);
        tbl[1]  = mk(1,1,1,1,1,1,1,7,31,0,0,1, 0,0,0,0,0,0,0,0,0);
        tbl[2]  = mk(0,1,1,1,0,0,0,0,5,0,0,0,  1,5,0,0,0,0,0,0,0);
        tbl[3]  = mk(0,0,1,0,1,0,1,2,9,0,0,0,  0,0,1,1,0,0,0,0,0);
        tbl[4]  = mk(0,1,1,1,0,1,0,0,7,0,0,0,  1,7,0,0,1,1,5,0,0);
        tbl[5]  = mk(0,1,1,0,0,0,0,0,8,1,0,0,  1,7,0,0,0,0,0,1,0);
        tbl[6]  = mk(0,1,1,0,0,0,0,0,8,0,0,0,  1,8,1,1,0,0,0,1,0);
        tbl[7]  = mk(0,1,0,0,0,0,1,1,0,0,0,1,  1,0,1,1,1,1,7,1,1);
        tbl[8]  = mk(0,0,0,0,0,0,0,0,0,1,0,0,  1,0,0,0,1,1,8,2,0);
        tbl[9]  = mk(0,1,1,0,0,0,0,0,3,1,1,1,  0,0,0,0,0,0,0,3,0);
        tbl[10] = mk(0,1,1,0,0,0,0,0,3,0,0,0,  1,3,0,0,0,0,0,3,0);
        tbl[11] = mk(0,1,1,0,0,0,0,0,4,0,1,0,  0,0,1,1,0,0,0,3,0);
        tbl[12] = mk(0,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,0,1,1,3,3,0);
        tbl[13] = mk(0,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0,0,0,4,0);
        tbl[14] = mk(0,1,1,0,0,0,0,0,10,0,0,0, 1,10,0,0,0,0,0,4,0);
        tbl[15] = mk(0,1,1,0,0,0,0,0,11,0,0,0, 1,11,1,1,0,0,0,4,0);
        tbl[16] = mk(0,1,1,0,0,0,0,0,12,0,0,0, 1,12,1,1,1,1,10,4,0);
        tbl[17] = mk(1,1,1,0,0,0,0,0,13,0,0,0, 0,0,0,0,0,0,0,0,0);
        tbl[18] = mk(0,1,1,0,0,0,0,0,14,0,0,0, 1,14,0,0,0,0,0,0,0);

        drive(1,0,0,0,0,0,0,3'd0,5'd0,0,0,0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            string t;
            vec_t  v;
            v = tbl[i];
            t = $sformatf("vec%0d", i);
            drive(v.r, v.vd, v.rw, v.asrc, v.mw, v.rs, v.br, v.alu, v.rd,
                  v.st, v.fl, v.z);
            @(posedge clk);
            #1;
            chk({t, " valid_e"}, 32'(b.valid_e), 32'(v.ve));
            chk({t, " rd_e"}, 32'(b.rd_e), 32'(v.rde));
            chk({t, " valid_m"}, 32'(b.valid_m), 32'(v.vm));
            chk({t, " reg_write_m"}, 32'(b.reg_write_m), 32'(v.rwm));
            chk({t, " valid_w"}, 32'(b.valid_w), 32'(v.vw));
            chk({t, " reg_write_w"}, 32'(b.reg_write_w), 32'(v.rww));
            chk({t, " rd_w"}, 32'(b.rd_w), 32'(v.rdw));
            chk({t, " retired_count"}, b.retired_count, v.cnt);
            chk({t, " pc_src_e"}, 32'(b.pc_src_e), 32'(v.pcs));
        end

        // Counter wrap: 17 back-to-back valid instructions from reset.
        drive(1,0,0,0,0,0,0,3'd0,5'd0,0,0,0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            drive(0,1,1,0,0,0,0,3'd0,5'(i + 1),0,0,0);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 4; i++) begin
            drive(0,0,0,0,0,0,0,3'd0,5'd0,0,0,0);
            @(posedge clk);
            #1;
        end
        chk("wrap count4", 32'(b4.retired_count), 32'd1);
        chk("wrap count32", b.retired_count, 32'd17);

        // Randomized run against the model.
        drive(1,0,0,0,0,0,0,3'd0,5'd0,0,0,0);
        @(posedge clk);
        #1;
        stg_e = '{default: '0};
        stg_m = '{default: '0};
        stg_w = '{default: '0};
        mcnt  = 0;
        for (int n = 0; n < 3000; n++) begin
            ins_t d, ne, nm, nw;
            logic r, st, fl;
            r  = ($urandom_range(0, 99) == 0);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 5) == 0);
            drive(r, 1'($urandom_range(0, 3) != 0), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  3'($urandom), 5'($urandom), st, fl, 1'($urandom));
            d = '{default: '0};
            if (b.valid_d) begin
                d = '{valid: 1'b1, rw: b.reg_write_d, asrc: b.alu_src_d,
                      mw: b.mem_write_d, rs: b.result_src_d,
                      br: b.branch_d, alu: b.alu_control_d, rd: b.rd_d};
            end
            ne = fl ? '{default: '0} : (st ? stg_e : d);
            nm = st ? '{default: '0} : stg_e;
            nw = stg_m;
            if (r) begin
                stg_e = '{default: '0};
                stg_m = '{default: '0};
                stg_w = '{default: '0};
                mcnt  = 0;
            end else begin
                mcnt  = mcnt + (stg_w.valid ? 32'd1 : 32'd0);
                stg_e = ne;
                stg_m = nm;
                stg_w = nw;
            end
            @(posedge clk);
            #1;
            cmp_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
